// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store.
// Data normally wins; fetch is forced through after STARVE_MAX back-to-back data grants.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ack_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_ack_o,
   output logic              m_req_o,
   output logic              m_we_o,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [DATA_W-1:0] m_wdata_o,
   input  logic [DATA_W-1:0] m_rdata_i,
   input  logic              m_ack_i,
   output logic              stall_o,
   output logic              err_o
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);
   localparam logic [TW-1:0] T_END = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state;
   logic              own_d;
   logic [SW-1:0]     starve_cnt;
   logic [TW-1:0]     to_cnt;
   logic              fetch_win;
   logic              done;
   logic [DATA_W-1:0] resp_data;

   assign fetch_win = if_req_i & (~d_req_i | (starve_cnt == S_MAX));
   assign done      = m_ack_i | (to_cnt == T_END);
   // stores and timed-out accesses return zero
   assign resp_data = (m_ack_i & ~m_we_o) ? m_rdata_i : '0;
   assign stall_o   = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         own_d      <= 1'b0;
         starve_cnt <= '0;
         to_cnt     <= '0;
         err_o      <= 1'b0;
         if_ack_o   <= 1'b0;
         d_ack_o    <= 1'b0;
         if_rdata_o <= '0;
         d_rdata_o  <= '0;
         m_req_o    <= 1'b0;
         m_we_o     <= 1'b0;
         m_addr_o   <= '0;
         m_wdata_o  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (if_req_i | d_req_i) begin
                  state   <= BUSY;
                  m_req_o <= 1'b1;
                  to_cnt  <= '0;
                  if (fetch_win) begin
                     own_d      <= 1'b0;
                     m_we_o     <= 1'b0;
                     m_addr_o   <= if_addr_i;
                     m_wdata_o  <= '0;
                     starve_cnt <= '0;
                  end else begin
                     own_d     <= 1'b1;
                     m_we_o    <= d_we_i;
                     m_addr_o  <= d_addr_i;
                     m_wdata_o <= d_wdata_i;
                     if (if_req_i && starve_cnt != S_MAX)
                        starve_cnt <= starve_cnt + 1'b1;
                  end
               end
            end
            BUSY: begin
               if (done) begin
                  state     <= RESP;
                  m_req_o   <= 1'b0;
                  m_we_o    <= 1'b0;
                  m_addr_o  <= '0;
                  m_wdata_o <= '0;
                  to_cnt    <= '0;
                  if (!m_ack_i)
                     err_o <= 1'b1;
                  if (own_d) begin
                     d_ack_o   <= 1'b1;
                     d_rdata_o <= resp_data;
                  end else begin
                     if_ack_o   <= 1'b1;
                     if_rdata_o <= resp_data;
                  end
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            RESP: begin
               state      <= IDLE;
               if_ack_o   <= 1'b0;
               d_ack_o    <= 1'b0;
               if_rdata_o <= '0;
               d_rdata_o  <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, corner sequences and a
// randomized run against a transaction-timeline reference model.
module tb_mem_port_arbiter;

   localparam int SMAX = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        if_ack_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [31:0] d_rdata_o;
   logic        d_ack_o;
   logic        m_req_o;
   logic        m_we_o;
   logic [31:0] m_addr_o;
   logic [31:0] m_wdata_o;
   logic [31:0] m_rdata_i;
   logic        m_ack_i;
   logic        stall_o;
   logic        err_o;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX), .TIMEOUT(64)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
      .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
      .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i), .m_ack_i(m_ack_i),
      .stall_o(stall_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wd;
   } g_t;

   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wd;
      int          lat;
      logic [31:0] rd;
      int          cyc;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;

   // memory model controls
   int          mem_lat = 1;
   bit          mem_dead = 0;
   bit          auto_mem = 1;
   bit          force_ack = 0;
   logic [31:0] force_rd = '0;

   // monitor results
   g_t grants[$];
   int req_cycles = 0;
   int we_cycles = 0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return (a == 32'h10) ? 32'h00A00093 : ~a;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      if_req_i = 1'b0; if_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
      step();
      step();
      rst_i = 1'b0;
   endtask

   task automatic wait_ack(input bit is_d, output int cyc,
                           output logic [31:0] rd, output bit oth);
      bit got;
      got = 0; cyc = 0; rd = '0; oth = 0;
      for (int c = 1; c <= 300 && !got; c++) begin
         if (is_d ? d_ack_o : if_ack_o) begin
            got = 1;
            cyc = c;
            rd  = is_d ? d_rdata_o : if_rdata_o;
            oth = is_d ? (if_ack_o | (|if_rdata_o))
                       : (d_ack_o | (|d_rdata_o));
         end else begin
            step();
         end
      end
   endtask

   // memory responder: ack after mem_lat cycles of m_req_o
   initial begin
      int bcnt;
      bcnt = 0;
      m_ack_i = 1'b0;
      m_rdata_i = '0;
      forever begin
         @(posedge clk_i);
         #3;
         if (!auto_mem) begin
            bcnt = 0;
            m_ack_i = force_ack;
            m_rdata_i = force_ack ? force_rd : 32'h0;
         end else if (m_ack_i) begin
            m_ack_i = 1'b0;
            m_rdata_i = '0;
            bcnt = 0;
         end else if (m_req_o) begin
            bcnt++;
            if (!mem_dead && bcnt == mem_lat) begin
               m_ack_i = 1'b1;
               m_rdata_i = m_we_o ? 32'hDEADBEEF : mem_rd(m_addr_o);
            end
         end else begin
            bcnt = 0;
         end
      end
   end

   initial begin
      bit prev;
      prev = 0;
      forever begin
         @(posedge clk_i);
         #4;
         if (m_req_o === 1'b1) begin
            req_cycles++;
            if (m_we_o) we_cycles++;
            if (!prev) grants.push_back({m_addr_o, m_we_o, m_wdata_o});
         end
         prev = (m_req_o === 1'b1);
      end
   end

   initial begin
      vec_t        vt[7];
      int          cyc, g0, r0, w0, dc, ic, acks;
      logic [31:0] rd;
      bit          oth, sbad, after_dack, bad;
      g_t          g;
      logic [9:0]  ord;
      // random-run model state
      bit          ip, dp, dwe, pi, pd, fwin, own_d, e_mreq, e_i, e_d, ewe;
      logic [31:0] ia, da, dw, eaddr, ewd, erd;
      int          free_at, rq_from, rq_to, ack_at, fwait, lat;

      vt[0] = '{0, 0, 32'h10,       32'h0,        2, 32'h00A00093, 4};
      vt[1] = '{1, 0, 32'h04,       32'h1111,     1, 32'hFFFFFFFB, 3};
      vt[2] = '{1, 1, 32'h08,       32'h5,        3, 32'h0,        5};
      vt[3] = '{0, 0, 32'hFFFFFFFC, 32'h0,        1, 32'h00000003, 3};
      vt[4] = '{1, 0, 32'h12345678, 32'h0,        4, 32'hEDCBA987, 6};
      vt[5] = '{1, 1, 32'h0,        32'hFFFFFFFF, 1, 32'h0,        3};
      vt[6] = '{0, 0, 32'h0,        32'h0,        3, 32'hFFFFFFFF, 5};

      do_reset();
      chk("reset_outs", 128'({if_ack_o, d_ack_o, m_req_o, m_we_o, err_o,
          m_addr_o, m_wdata_o, if_rdata_o, d_rdata_o}), 128'(0));
      chk("reset_stall", 128'(stall_o), 128'(0));

      // single-access vector table
      for (int i = 0; i < 7; i++) begin
         mem_lat = vt[i].lat;
         g0 = grants.size(); r0 = req_cycles; w0 = we_cycles;
         if (vt[i].is_d) begin
            d_req_i = 1'b1; d_we_i = vt[i].we;
            d_addr_i = vt[i].addr; d_wdata_i = vt[i].wd;
         end else begin
            if_req_i = 1'b1; if_addr_i = vt[i].addr;
         end
         wait_ack(vt[i].is_d, cyc, rd, oth);
         chk($sformatf("vec%0d_cyc", i), 128'(cyc), 128'(vt[i].cyc));
         chk($sformatf("vec%0d_rdata", i), 128'(rd), 128'(vt[i].rd));
         chk($sformatf("vec%0d_other", i), 128'(oth), 128'(0));
         step();
         if_req_i = 1'b0; d_req_i = 1'b0;
         step();
         g = (grants.size() > g0) ? grants[g0] : '0;
         chk($sformatf("vec%0d_ngrant", i), 128'(grants.size() - g0), 128'(1));
         chk($sformatf("vec%0d_mfields", i), 128'(g),
             128'({vt[i].addr, vt[i].we, (vt[i].is_d ? vt[i].wd : 32'h0)}));
         chk($sformatf("vec%0d_reqcyc", i), 128'(req_cycles - r0), 128'(vt[i].lat));
         chk($sformatf("vec%0d_wecyc", i), 128'(we_cycles - w0),
             128'(vt[i].we ? vt[i].lat : 0));
      end

      // simultaneous store and fetch
      do_reset();
      mem_lat = 1;
      g0 = grants.size();
      if_req_i = 1'b1; if_addr_i = 32'h40;
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h4; d_wdata_i = 32'h5;
      #1;
      chk("t2_stall_start", 128'(stall_o), 128'(1));
      dc = 0; ic = 0; sbad = 0; after_dack = 1; rd = '0;
      for (int c = 1; c <= 100 && ic == 0; c++) begin
         step();
         if (dc != 0 && c == dc + 1) begin
            d_req_i = 1'b0;
            after_dack = d_ack_o;
         end
         if (d_ack_o && dc == 0) dc = c;
         if (if_ack_o) begin
            ic = c;
            rd = if_rdata_o;
         end
         #1;
         if (stall_o !== ((ic == 0) ? 1'b1 : 1'b0)) sbad = 1;
      end
      chk("t2_order", 128'(dc > 0 && ic > dc), 128'(1));
      chk("t2_dack_drop", 128'(after_dack), 128'(0));
      g = (grants.size() > g0) ? grants[g0] : '0;
      chk("t2_grant_d", 128'(g), 128'({32'h4, 1'b1, 32'h5}));
      g = (grants.size() > g0 + 1) ? grants[g0 + 1] : '0;
      chk("t2_grant_f", 128'(g), 128'({32'h40, 1'b0, 32'h0}));
      chk("t2_frdata", 128'(rd), 128'(32'hFFFFFFBF));
      chk("t2_stall", 128'(sbad), 128'(0));
      step();
      if_req_i = 1'b0;
      step();

      // continuous contention: starvation guard
      do_reset();
      mem_lat = 1;
      g0 = grants.size();
      if_req_i = 1'b1; if_addr_i = 32'h200;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h100;
      acks = 0;
      for (int c = 0; c < 300 && acks < 10; c++) begin
         step();
         if (if_ack_o | d_ack_o) acks++;
      end
      step();
      if_req_i = 1'b0; d_req_i = 1'b0;
      step();
      chk("t3_ngrant", 128'(grants.size() - g0), 128'(10));
      ord = '0;
      for (int k = 0; k < 10; k++)
         if (grants.size() > g0 + k)
            ord[k] = (grants[g0 + k].addr == 32'h200);
      chk("t3_order", 128'(ord), 128'(10'b10_0001_0000));

      // memory never acknowledges
      do_reset();
      mem_dead = 1;
      r0 = req_cycles;
      if_req_i = 1'b1; if_addr_i = 32'h10;
      wait_ack(0, cyc, rd, oth);
      chk("t4_acked", 128'(cyc != 0), 128'(1));
      chk("t4_rdata", 128'(rd), 128'(0));
      chk("t4_err", 128'(err_o), 128'(1));
      step();
      if_req_i = 1'b0;
      chk("t4_reqcyc", 128'(req_cycles - r0), 128'(64));
      mem_dead = 0;
      mem_lat = 1;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h20;
      wait_ack(1, cyc, rd, oth);
      chk("t4_next_rdata", 128'(rd), 128'(32'hFFFFFFDF));
      chk("t4_err_sticky", 128'(err_o), 128'(1));
      step();
      d_req_i = 1'b0;
      do_reset();
      chk("t4_err_clr", 128'(err_o), 128'(0));

      // reset during BUSY, then stray ack in IDLE
      auto_mem = 0;
      force_ack = 0;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h30;
      step();
      chk("t5_busy", 128'(m_req_o), 128'(1));
      step();
      rst_i = 1'b1;
      d_req_i = 1'b0;
      step();
      rst_i = 1'b0;
      chk("t5_reset_outs", 128'(|{if_ack_o, d_ack_o, m_req_o, m_we_o, err_o,
          m_addr_o, m_wdata_o, if_rdata_o, d_rdata_o}), 128'(0));
      force_ack = 1; force_rd = 32'h55AA55AA;
      step();
      force_ack = 0;
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (if_ack_o | d_ack_o | m_req_o | err_o | (|d_rdata_o)) bad = 1;
      end
      chk("t5_stray", 128'(bad), 128'(0));
      auto_mem = 1;
      mem_lat = 2;
      if_req_i = 1'b1; if_addr_i = 32'h10;
      wait_ack(0, cyc, rd, oth);
      chk("t5_next_cyc", 128'(cyc), 128'(4));
      chk("t5_next_rdata", 128'(rd), 128'(32'h00A00093));
      step();
      if_req_i = 1'b0;

      // fetch presented right after a load ack
      do_reset();
      mem_lat = 1;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h4;
      wait_ack(1, cyc, rd, oth);
      chk("t6_drdata", 128'(rd), 128'(32'hFFFFFFFB));
      step();
      d_req_i = 1'b0;
      if_req_i = 1'b1; if_addr_i = 32'h80;
      step();
      chk("t6_switch", 128'({m_req_o, m_addr_o}), 128'({1'b1, 32'h80}));
      wait_ack(0, cyc, rd, oth);
      chk("t6_frdata", 128'(rd), 128'(32'hFFFFFF7F));
      step();
      if_req_i = 1'b0;

      // randomized traffic against a timeline model
      do_reset();
      ip = 0; dp = 0; pi = 0; pd = 0; dwe = 0;
      ia = '0; da = '0; dw = '0;
      own_d = 0; ewe = 0; eaddr = '0; ewd = '0; erd = '0;
      free_at = 0; rq_from = -1; rq_to = -2; ack_at = -1; fwait = 0;
      for (int t = 0; t < 3000; t++) begin
         step();
         if (pi) ip = 0;
         if (pd) dp = 0;
         if (!ip && $urandom_range(0, 3) != 0) begin
            ip = 1; ia = $urandom;
         end
         if (!dp && $urandom_range(0, 3) != 0) begin
            dp = 1; da = $urandom; dw = $urandom;
            dwe = ($urandom_range(0, 1) == 1);
         end
         if_req_i = ip; if_addr_i = ia;
         d_req_i = dp; d_we_i = dwe; d_addr_i = da; d_wdata_i = dw;
         e_mreq = (t >= rq_from) && (t <= rq_to);
         e_i = (t == ack_at) && !own_d;
         e_d = (t == ack_at) && own_d;
         chk("rnd_mem", 128'({m_req_o, m_we_o, m_addr_o, m_wdata_o}),
             128'({e_mreq, e_mreq & ewe, e_mreq ? eaddr : 32'h0,
                   e_mreq ? ewd : 32'h0}));
         chk("rnd_ack", 128'({err_o, if_ack_o, if_rdata_o, d_ack_o, d_rdata_o}),
             128'({1'b0, e_i, e_i ? erd : 32'h0, e_d, e_d ? erd : 32'h0}));
         if (t >= free_at && (ip || dp)) begin
            fwin = ip && (!dp || fwait == SMAX);
            lat = $urandom_range(1, 5);
            mem_lat = lat;
            rq_from = t + 1; rq_to = t + lat;
            ack_at = t + lat + 1; free_at = t + lat + 2;
            own_d = !fwin;
            eaddr = fwin ? ia : da;
            ewe = fwin ? 1'b0 : dwe;
            ewd = fwin ? 32'h0 : dw;
            erd = fwin ? mem_rd(ia) : (dwe ? 32'h0 : mem_rd(da));
            if (fwin) fwait = 0;
            else if (ip && fwait < SMAX) fwait++;
         end
         #1;
         chk("rnd_stall", 128'(stall_o), 128'((ip & !e_i) | (dp & !e_d)));
         pi = e_i; pd = e_d;
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
